// File: rtl/lcd_hd44780_ctrl_pkg.sv
// Shared definitions for the HD44780 4-bit controller: FSM encodings, LCD command
// constants and small helpers used by the controller and the message/effect engine.
package lcd_hd44780_ctrl_pkg;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_DISP_OFF = 8'h08;

  localparam logic [3:0] NIB_INIT_8BIT = 4'h3;
  localparam logic [3:0] NIB_INIT_4BIT = 4'h2;

  // Four single nibbles plus five full bytes make up the power-on sequence.
  localparam logic [3:0] INIT_STEPS = 4'd9;

  typedef enum logic [1:0] {
    STB_IDLE,
    STB_SETUP,
    STB_HIGH,
    STB_HOLD
  } strobe_state_t;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_HI,
    ST_LO,
    ST_WAIT,
    ST_IDLE
  } ctrl_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_clear_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_nibble_strobe.sv
// One nibble transfer on the LCD pins: SETUP (data valid, E low), E high for E_CYC
// cycles, then HOLD (E low, data held). A new start during HOLD chains without a gap.
module lcd_hd44780_ctrl_nibble_strobe
  import lcd_hd44780_ctrl_pkg::*;
#(
  parameter int E_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nibble,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d,
  output logic       done
);

  localparam int HW = (E_CYC > 1) ? $clog2(E_CYC) : 1;
  localparam logic [HW-1:0] H_LAST = HW'(E_CYC - 1);

  strobe_state_t state, state_nx;
  logic          rs_q, rs_nx;
  logic [3:0]    nib_q, nib_nx;
  logic [HW-1:0] hcnt, hcnt_nx;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path can infer a latch.
    state_nx = state;
    rs_nx    = rs_q;
    nib_nx   = nib_q;
    hcnt_nx  = hcnt;
    case (state)
      STB_IDLE, STB_HOLD: begin
        if (start) begin
          state_nx = STB_SETUP;
          rs_nx    = rs;
          nib_nx   = nibble;
        end else begin
          state_nx = STB_IDLE;
        end
      end
      STB_SETUP: begin
        state_nx = STB_HIGH;
        hcnt_nx  = '0;
      end
      STB_HIGH: begin
        if (hcnt == H_LAST) state_nx = STB_HOLD;
        else                hcnt_nx  = hcnt + 1'b1;
      end
      default: state_nx = STB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= STB_IDLE;
      rs_q  <= 1'b0;
      nib_q <= 4'h0;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      rs_q  <= rs_nx;
      nib_q <= nib_nx;
      hcnt  <= hcnt_nx;
    end
  end

  assign lcd_e  = (state == STB_HIGH);
  assign lcd_rs = (state != STB_IDLE) && rs_q;
  assign lcd_d  = (state != STB_IDLE) ? nib_q : 4'h0;
  assign done   = (state == STB_HOLD);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit-bus controller: runs the power-on init sequence, then sends client
// command/data bytes as two nibble strobes followed by an open-loop execution wait.
module lcd_hd44780_ctrl
  import lcd_hd44780_ctrl_pkg::*;
#(
  parameter int         PWRUP_CYC  = 40000,
  parameter int         INIT1_CYC  = 4100,
  parameter int         INIT2_CYC  = 100,
  parameter int         CMD_CYC    = 40,
  parameter int         CLR_CYC    = 1600,
  parameter int         E_CYC      = 1,
  parameter logic [7:0] FUNC_SET   = 8'h28,
  parameter logic [7:0] ENTRY_MODE = 8'h06,
  parameter logic [7:0] DISP_CTRL  = 8'h0C
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       init_done,
  output logic       RS,
  output logic       E,
  output logic [3:0] D
);

  localparam int CW = $clog2(max3(PWRUP_CYC, INIT1_CYC, CLR_CYC) + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t W_PWRUP = cnt_t'(PWRUP_CYC);
  localparam cnt_t W_INIT1 = cnt_t'(INIT1_CYC);
  localparam cnt_t W_INIT2 = cnt_t'(INIT2_CYC);
  localparam cnt_t W_CMD   = cnt_t'(CMD_CYC);
  localparam cnt_t W_CLR   = cnt_t'(CLR_CYC);

  ctrl_state_t state, state_nx;
  cnt_t        cnt, cnt_nx, wait_len, wait_len_nx;
  logic [3:0]  step, step_nx;
  logic [7:0]  cur_data, cur_data_nx;
  logic        cur_rs, cur_rs_nx;
  logic        single, single_nx;
  logic        init_done_nx;

  logic        item_single;
  logic [7:0]  item_data;
  cnt_t        item_wait;

  logic        stb_start, stb_rs, stb_done;
  logic [3:0]  stb_nib;
  logic        wait_over;

  // Init step table: steps 0..3 are single nibbles, the rest are full bytes.
  always_comb begin
    item_single = 1'b0;
    item_data   = 8'h00;
    item_wait   = W_CMD;
    case (step)
      4'd0: begin item_single = 1'b1; item_data = {4'h0, NIB_INIT_8BIT}; item_wait = W_INIT1; end
      4'd1: begin item_single = 1'b1; item_data = {4'h0, NIB_INIT_8BIT}; item_wait = W_INIT2; end
      4'd2: begin item_single = 1'b1; item_data = {4'h0, NIB_INIT_8BIT}; end
      4'd3: begin item_single = 1'b1; item_data = {4'h0, NIB_INIT_4BIT}; end
      4'd4: item_data = FUNC_SET;
      4'd5: item_data = CMD_DISP_OFF;
      4'd6: item_data = CMD_CLEAR;
      4'd7: item_data = ENTRY_MODE;
      4'd8: item_data = DISP_CTRL;
      default: item_data = 8'h00;
    endcase
    if (!item_single) item_wait = is_clear_cmd(1'b0, item_data) ? W_CLR : W_CMD;
  end

  assign wait_over = ((state == ST_PWRUP) && (cnt == W_PWRUP)) ||
                     ((state == ST_WAIT)  && (cnt == wait_len));

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    wait_len_nx  = wait_len;
    step_nx      = step;
    cur_data_nx  = cur_data;
    cur_rs_nx    = cur_rs;
    single_nx    = single;
    init_done_nx = init_done;
    stb_start    = 1'b0;
    stb_rs       = 1'b0;
    stb_nib      = 4'h0;
    case (state)
      ST_PWRUP, ST_WAIT: begin
        if (!wait_over) cnt_nx = cnt + 1'b1;
      end
      ST_IDLE: begin
        if (in_valid) begin
          stb_start   = 1'b1;
          stb_rs      = in_rs;
          stb_nib     = in_data[7:4];
          cur_rs_nx   = in_rs;
          cur_data_nx = in_data;
          single_nx   = 1'b0;
          wait_len_nx = is_clear_cmd(in_rs, in_data) ? W_CLR : W_CMD;
          state_nx    = ST_HI;
        end
      end
      ST_HI: begin
        if (stb_done) begin
          if (single) begin
            state_nx = ST_WAIT;
            cnt_nx   = cnt_t'(1);
          end else begin
            stb_start = 1'b1;
            stb_rs    = cur_rs;
            stb_nib   = cur_data[3:0];
            state_nx  = ST_LO;
          end
        end
      end
      ST_LO: begin
        if (stb_done) begin
          state_nx = ST_WAIT;
          cnt_nx   = cnt_t'(1);
        end
      end
      default: state_nx = ST_PWRUP;
    endcase

    // The last wait cycle launches the next init item, or opens the client port.
    if (wait_over) begin
      if (step < INIT_STEPS) begin
        stb_start   = 1'b1;
        stb_rs      = 1'b0;
        stb_nib     = item_single ? item_data[3:0] : item_data[7:4];
        cur_rs_nx   = 1'b0;
        cur_data_nx = item_data;
        single_nx   = item_single;
        wait_len_nx = item_wait;
        step_nx     = step + 4'd1;
        state_nx    = ST_HI;
      end else begin
        state_nx     = ST_IDLE;
        init_done_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= ST_PWRUP;
      cnt       <= '0;
      wait_len  <= '0;
      step      <= 4'd0;
      cur_data  <= 8'h00;
      cur_rs    <= 1'b0;
      single    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      wait_len  <= wait_len_nx;
      step      <= step_nx;
      cur_data  <= cur_data_nx;
      cur_rs    <= cur_rs_nx;
      single    <= single_nx;
      init_done <= init_done_nx;
    end
  end

  assign in_ready = (state == ST_IDLE);

  lcd_hd44780_ctrl_nibble_strobe #(
    .E_CYC(E_CYC)
  ) u_strobe (
    .clk   (CLK),
    .rst_n (RST),
    .start (stb_start),
    .rs    (stb_rs),
    .nibble(stb_nib),
    .lcd_rs(RS),
    .lcd_e (E),
    .lcd_d (D),
    .done  (stb_done)
  );

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Self-checking bench for lcd_hd44780_ctrl: scoreboard of expected nibble strobes and
// in_ready low periods, compared by a pin monitor as the controller produces them.
module tb_lcd_hd44780_ctrl;

  localparam int PWRUP    = 20;
  localparam int INIT1    = 8;
  localparam int INIT2    = 4;
  localparam int CMD      = 3;
  localparam int CLR      = 6;
  localparam int ECYC     = 2;
  localparam int BYTE_RUN = 2 * (ECYC + 2);

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, init_done, RS, E;
  logic [3:0] D;

  always #5 CLK = ~CLK;

  lcd_hd44780_ctrl #(
    .PWRUP_CYC (PWRUP),
    .INIT1_CYC (INIT1),
    .INIT2_CYC (INIT2),
    .CMD_CYC   (CMD),
    .CLR_CYC   (CLR),
    .E_CYC     (ECYC),
    .FUNC_SET  (8'h28),
    .ENTRY_MODE(8'h06),
    .DISP_CTRL (8'h0C)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .init_done(init_done),
    .RS       (RS),
    .E        (E),
    .D        (D)
  );

  // gap = E-low cycles before the strobe (HOLD + wait + SETUP); -1 = not checked
  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         gap;
  } nib_t;

  nib_t exp_q[$];
  int   rdy_q[$];
  int   tests = 0;
  int   fails = 0;
  int   accepts = 0;
  int   sends = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, required %0d", tag, obs, exp);
    end
  endtask

  task automatic push_nib(input logic rs, input logic [3:0] nib, input int gap);
    nib_t t;
    t.rs  = rs;
    t.nib = nib;
    t.gap = gap;
    exp_q.push_back(t);
  endtask

  task automatic push_init_byte(input logic [7:0] b, input int gap);
    push_nib(1'b0, b[7:4], gap);
    push_nib(1'b0, b[3:0], 2);
  endtask

  task automatic push_init();
    push_nib(1'b0, 4'h3, PWRUP + 1);
    push_nib(1'b0, 4'h3, INIT1 + 2);
    push_nib(1'b0, 4'h3, INIT2 + 2);
    push_nib(1'b0, 4'h2, CMD + 2);
    push_init_byte(8'h28, CMD + 2);
    push_init_byte(8'h08, CMD + 2);
    push_init_byte(8'h01, CMD + 2);
    push_init_byte(8'h06, CLR + 2);
    push_init_byte(8'h0C, CMD + 2);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic rs, input logic [7:0] data, input logic hold);
    int n;
    int w;
    sends++;
    w = (!rs && data >= 8'h01 && data <= 8'h03) ? CLR : CMD;
    push_nib(rs, data[7:4], -1);
    push_nib(rs, data[3:0], 2);
    rdy_q.push_back(BYTE_RUN + w);
    in_valid = 1'b1;
    in_rs    = rs;
    in_data  = data;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check("send_ready", in_ready, 1);
    @(negedge CLK);
    in_data = ~data;
    in_rs   = ~rs;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check(tag, in_ready, 1);
  endtask

  // Pin monitor: samples 1 time unit after each rising edge.
  logic       rst_e, acc;
  logic       e_p = 1'b0, rdy_p = 1'b0, id_p = 1'b0;
  logic       rs_p = 1'b0, rs_p2 = 1'b0;
  logic [3:0] d_p = 4'h0, d_p2 = 4'h0;
  int         low_run = 0, rdy_run = 0, hi_cnt = 0, rdy_exp;
  nib_t       cur;

  always @(posedge CLK) begin
    rst_e = RST;
    acc   = RST && in_valid && in_ready;
    #1;
    if (!rst_e) begin
      exp_q.delete();
      rdy_q.delete();
      low_run = 0;
      rdy_run = 0;
      hi_cnt  = 0;
    end else begin
      if (acc) begin
        accepts++;
        check("accept_after_init", id_p, 1);
        check("ready_drop_after_accept", in_ready, 0);
        rdy_run = 0;
      end
      if (!init_done) check("ready_low_during_init", in_ready, 0);

      if (E && !e_p) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_queue", exp_q.size(), 1);
          cur.rs  = RS;
          cur.nib = D;
          cur.gap = -1;
        end else begin
          cur = exp_q.pop_front();
          check("strobe_rs", RS, cur.rs);
          check("strobe_d", D, cur.nib);
          check("setup_rs", rs_p, cur.rs);
          check("setup_d", d_p, cur.nib);
          if (cur.gap >= 0) check("strobe_gap", low_run, cur.gap);
          if (cur.gap > 2) begin
            check("wait_d_zero", d_p2, 0);
            check("wait_rs_zero", rs_p2, 0);
          end
        end
        hi_cnt = 1;
      end else if (E && e_p) begin
        hi_cnt++;
        check("high_d_stable", D, cur.nib);
      end else if (!E && e_p) begin
        check("e_width", hi_cnt, ECYC);
        check("hold_d", D, cur.nib);
        check("hold_rs", RS, cur.rs);
        low_run = 1;
      end else begin
        low_run++;
      end

      if (!in_ready) rdy_run++;
      if (init_done && !id_p) begin
        check("ready_with_init_done", in_ready, 1);
        check("init_done_gap", low_run, CMD + 2);
      end else if (in_ready && !rdy_p && id_p) begin
        if (rdy_q.size() == 0) begin
          check("unexpected_ready_queue", rdy_q.size(), 1);
        end else begin
          rdy_exp = rdy_q.pop_front();
          check("ready_low_cycles", rdy_run, rdy_exp);
        end
      end
    end
    d_p2  = d_p;
    rs_p2 = rs_p;
    d_p   = rst_e ? D : 4'h0;
    rs_p  = rst_e ? RS : 1'b0;
    e_p   = rst_e ? E : 1'b0;
    rdy_p = in_ready;
    id_p  = init_done;
  end

  initial begin
    int n;
    RST      = 1'b0;
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'hAA;
    repeat (3) @(negedge CLK);
    check("rst_E", E, 0);
    check("rst_D", D, 0);
    check("rst_RS", RS, 0);
    check("rst_ready", in_ready, 0);
    check("rst_init_done", init_done, 0);

    // Init with in_valid held high; then back-to-back bytes.
    push_init();
    RST = 1'b1;
    send_byte(1'b1, 8'hAA, 1'b1);
    send_byte(1'b1, 8'h5C, 1'b1);
    send_byte(1'b0, 8'h80, 1'b0);
    repeat (4) @(negedge CLK);

    // Single bytes covering both wait lengths and the clear/home boundaries.
    send_byte(1'b1, 8'h41, 1'b0);
    repeat (3) @(negedge CLK);
    send_byte(1'b0, 8'h01, 1'b0);
    send_byte(1'b1, 8'h01, 1'b0);
    send_byte(1'b0, 8'h03, 1'b0);
    send_byte(1'b0, 8'h04, 1'b0);
    send_byte(1'b0, 8'h00, 1'b0);
    wait_ready("drain_ready");

    // Reset asserted during the E-high cycle of a data nibble.
    sends++;
    push_nib(1'b1, 4'h5, -1);
    in_valid = 1'b1;
    in_rs    = 1'b1;
    in_data  = 8'h55;
    @(negedge CLK);
    in_valid = 1'b0;
    n = 0;
    while (!E && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("mid_strobe_e_high", E, 1);
    RST = 1'b0;
    @(negedge CLK);
    check("mid_rst_E", E, 0);
    check("mid_rst_D", D, 0);
    check("mid_rst_RS", RS, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_init_done", init_done, 0);
    @(negedge CLK);
    push_init();
    RST = 1'b1;
    n = 0;
    while (!init_done && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    check("reinit_done", init_done, 1);
    send_byte(1'b1, 8'h7E, 1'b0);
    wait_ready("final_ready");
    repeat (2) @(negedge CLK);

    check("strobe_queue_empty", exp_q.size(), 0);
    check("ready_queue_empty", rdy_q.size(), 0);
    check("accept_count", accepts, sends);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
